// File: rtl/watch_bcd2bin_if.sv
// Handshake and data bundle between the watch control block and the
// BCD-to-binary converter.
interface watch_bcd2bin_if;
   logic        start;
   logic [23:0] bcd_in;
   logic        busy;
   logic        done;
   logic        error;
   logic [17:0] time_data;

   // Requester side: issues start/bcd_in, observes status and result.
   modport master (
      output start, bcd_in,
      input  busy, done, error, time_data
   );

   // Converter side.
   modport slave (
      input  start, bcd_in,
      output busy, done, error, time_data
   );
endinterface

// File: rtl/watch_bcd2bin.sv
// Sequential BCD-to-binary converter for hh:mm:ss. The three fields are
// converted in parallel by a 7-step reverse double-dabble, range-checked,
// and the packed {hour, minute, second} word is released on success.
module watch_bcd2bin #(
   parameter int unsigned HOUR_MAX = 23
) (
   input  logic            clock,
   input  logic            reset,
   watch_bcd2bin_if.slave  bus
);

   typedef enum logic [1:0] {IDLE, CONV, CHECK} state_t;

   localparam logic [6:0] HOUR_LIM = 7'(HOUR_MAX);
   localparam logic [6:0] MS_LIM   = 7'd59;

   state_t          state, state_nxt;
   logic            load, step, check;
   logic [2:0]      cnt;
   logic [2:0][7:0] bcd;     // [2]=hour, [1]=minute, [0]=second
   logic [2:0][6:0] bin;
   logic            nib_ok;
   logic            result_ok;

   // One reverse double-dabble step on a {bcd, bin} pair: shift right one
   // bit, then pull any nibble that reached 8 or more back down by 3.
   function automatic logic [14:0] dabble(input logic [14:0] v);
      logic [7:0] b;
      logic [6:0] n;
      {b, n} = {1'b0, v[14:1]};
      if (b[7:4] >= 4'd8) b[7:4] = b[7:4] - 4'd3;
      if (b[3:0] >= 4'd8) b[3:0] = b[3:0] - 4'd3;
      return {b, n};
   endfunction

   // True when every nibble of the raw input is a decimal digit.
   function automatic logic digits_ok(input logic [23:0] v);
      logic ok;
      ok = 1'b1;
      for (int i = 0; i < 6; i++)
         if (v[i*4 +: 4] > 4'd9) ok = 1'b0;
      return ok;
   endfunction

   assign result_ok = nib_ok && (bin[2] <= HOUR_LIM) &&
                      (bin[1] <= MS_LIM) && (bin[0] <= MS_LIM);

   // State register.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state and per-cycle control strobes.
   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      step      = 1'b0;
      check     = 1'b0;
      case (state)
         IDLE: begin
            if (bus.start) begin
               load      = 1'b1;
               state_nxt = CONV;
            end
         end
         CONV: begin
            step = 1'b1;
            if (cnt == 3'd6) state_nxt = CHECK;
         end
         CHECK: begin
            check     = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Datapath and registered outputs; result/error move only on CHECK.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         cnt           <= '0;
         bcd           <= '0;
         bin           <= '0;
         nib_ok        <= 1'b0;
         bus.busy      <= 1'b0;
         bus.done      <= 1'b0;
         bus.error     <= 1'b0;
         bus.time_data <= '0;
      end else begin
         bus.busy <= (state_nxt != IDLE);
         bus.done <= check;
         if (load) begin
            bcd    <= {bus.bcd_in[23:16], bus.bcd_in[15:8], bus.bcd_in[7:0]};
            bin    <= '0;
            cnt    <= '0;
            nib_ok <= digits_ok(bus.bcd_in);
         end
         if (step) begin
            for (int i = 0; i < 3; i++)
               {bcd[i], bin[i]} <= dabble({bcd[i], bin[i]});
            cnt <= cnt + 3'd1;
         end
         if (check) begin
            if (result_ok) begin
               bus.time_data <= {bin[2][5:0], bin[1][5:0], bin[0][5:0]};
               bus.error     <= 1'b0;
            end else begin
               bus.error     <= 1'b1;
            end
         end
      end
   end

endmodule

// File: doc/watch_bcd2bin.md
# watch_bcd2bin

Sequential BCD-to-binary converter for the digital watch. It takes a 6-digit BCD time (hh:mm:ss), as entered from a keypad or received from an external time source. It returns the packed binary time word that the control block consumes: hour[17:12], minute[11:6], second[5:0]. It is the inverse of the binary-to-BCD path that feeds the seven-segment displays, and it range-checks every field before releasing the result.

## Interface

Parameters:
- HOUR_MAX, default 23: largest legal hour value. Set to 12 for 12-hour entry.

Ports:
- clock  input  1  system clock, 50 MHz domain; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset. Asserting (0) immediately forces reset state; release is synchronous to clock upstream.
- start  input  1  request pulse; sampled only in IDLE.
- bcd_in  input  24  BCD time: [23:20] hour tens, [19:16] hour units, [15:12] minute tens, [11:8] minute units, [7:4] second tens, [3:0] second units.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse when a conversion finishes, with or without error.
- error  output  1  result of the last completed conversion: 1 if it was rejected.
- time_data  output  18  last accepted binary time, packed {hour[5:0], minute[5:0], second[5:0]}.

## Operation

- FSM states: IDLE, CONV, CHECK.
  - IDLE: on start=1, latch bcd_in into three 8-bit BCD shift registers (one per field), clear the three 7-bit binary accumulators, set the iteration counter to 0, and set busy=1. Then go to CONV.
  - CONV: each cycle, apply one reverse double-dabble step to every field in parallel:
    - shift {bcd, bin} right 1 bit;
    - then, for each BCD nibble, subtract 3 if the nibble is ≥8.
    - After exactly 7 steps (counter 0..6), go to CHECK.
  - CHECK: evaluate the error conditions below, update the outputs, pulse done, clear busy, and return to IDLE.
- Nibble validity is evaluated on the latched input at start acceptance and held in a flag until CHECK. Any nibble >9 makes the conversion invalid.
- Range checks are made on the 7-bit results in CHECK:
  - hour > HOUR_MAX is invalid;
  - minute > 59 is invalid;
  - second > 59 is invalid.
- On a valid conversion: time_data is set to the low 6 bits of each field and error=0.
- On an invalid conversion: time_data keeps its previous value and error=1.
- error holds until the next CHECK.
- start asserted while busy=1 is ignored. It is not queued.
- bcd_in is only sampled at acceptance, so later changes have no effect on the conversion in progress.

## Timing

- Reset values (while reset=0): state IDLE, busy=0, done=0, error=0, time_data=18'h00000, counter=0.
- Let edge 0 be the rising edge that accepts start. The sequence is:
  - busy=1 from edge 0;
  - CONV steps occur on edges 1–7;
  - CHECK occurs on edge 8, where done=1, busy=0, and time_data/error are updated.
  - done returns to 0 on edge 9.
- Latency from start acceptance to done is 8 cycles.
- The earliest next acceptance is edge 9 (start high in the cycle after done). Throughput is 1 conversion per 9 cycles.
- start held high continuously retriggers at edges 0, 9, 18, …
- If reset is asserted mid-conversion, the conversion is abandoned: no done pulse, and all outputs take their reset values immediately.
- time_data and error change only on a CHECK edge or on reset. No glitches on intermediate steps.

## Test plan

- After reset, start with bcd_in=24'h235959 → at edge 8: done=1, error=0, time_data=18'h17EFB. busy was high for edges 0–7.
- start with bcd_in=24'h123456 → time_data=18'h0C8B8, error=0, done pulse exactly 1 cycle wide. Then bcd_in=24'h000000 → time_data=18'h00000.
- After a valid 12:34:56 conversion, start with 24'h240000, then 24'h126000, then 24'h12345A → each gives error=1 with time_data remaining 18'h0C8B8. A following valid 01:02:03 clears error and gives time_data=18'h01083.
- Pulse start again at edges 3 and 8 during a conversion → exactly one done, at edge 8, with no extra conversion started.
- Assert reset at edge 4 of a conversion → busy, done, error, and time_data are 0 immediately. No done appears afterward. A new start after release converts normally.
- With HOUR_MAX=12: 13:00:00 → error=1; 12:00:00 → time_data=18'h0C000, error=0.
